// File: rtl/riscv_mult_serial_if.sv
// Handshake/operand bundle for riscv_mult_serial.
//   master : drives operands, opcode, InVld_SI and OutRdy_SI; sees InRdy_SO, OutVld_SO, Res_DO
//   slave  : the multiplier side of the same signals
interface riscv_mult_serial_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH-1:0] OpA_DI;
  logic [C_WIDTH-1:0] OpB_DI;
  logic [1:0]         OpCode_SI;
  logic               InVld_SI;
  logic               InRdy_SO;
  logic               OutVld_SO;
  logic               OutRdy_SI;
  logic [C_WIDTH-1:0] Res_DO;

  modport master (
    output OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
    input  InRdy_SO, OutVld_SO, Res_DO
  );

  modport slave (
    input  OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
    output InRdy_SO, OutVld_SO, Res_DO
  );
endinterface

// File: rtl/riscv_mult_serial.sv
// Serial shift-and-add multiplier for the RISC-V MUL/MULH/MULHSU/MULHU ops.
// Operands are converted to magnitudes on capture, multiplied unsigned over
// C_WIDTH cycles, and the sign is reapplied on the output path.
// Ports:
//   Clk_CI   clock, rising edge
//   Rst_RBI  asynchronous active-low reset
//   bus      slave side of riscv_mult_serial_if (operands, opcode, in/out handshakes, result)
module riscv_mult_serial #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input logic                Clk_CI,
  input logic                Rst_RBI,
  riscv_mult_serial_if.slave bus
);

`ifndef SKIP_ASSERT
  if (C_LOG_WIDTH != $clog2(C_WIDTH + 1)) begin : g_bad_log_width
    $error("riscv_mult_serial: C_LOG_WIDTH must equal $clog2(C_WIDTH+1)");
  end
`endif

  typedef enum logic [1:0] {IDLE, MULT, FINISH} state_e;

  state_e                 state_q, state_d;
  logic [2*C_WIDTH-1:0]   prod_q;
  logic [C_WIDTH-1:0]     a_mag_q;
  logic [C_LOG_WIDTH-1:0] cnt_q;
  logic                   res_inv_q, hi_sel_q;

  // Capture-side decode
  logic               a_sgn, b_sgn, a_neg, b_neg;
  logic [C_WIDTH-1:0] a_mag, b_mag;

  assign a_sgn = (bus.OpCode_SI == 2'd1) || (bus.OpCode_SI == 2'd2);
  assign b_sgn = (bus.OpCode_SI == 2'd1);
  assign a_neg = a_sgn & bus.OpA_DI[C_WIDTH-1];
  assign b_neg = b_sgn & bus.OpB_DI[C_WIDTH-1];
  // Most negative value maps to 2^(C_WIDTH-1), which still fits unsigned.
  assign a_mag = a_neg ? -bus.OpA_DI : bus.OpA_DI;
  assign b_mag = b_neg ? -bus.OpB_DI : bus.OpB_DI;

  // One shift-and-add step; the adder carry is kept as bit C_WIDTH of sum
  // so the shifted-in MSB is never lost.
  logic [C_WIDTH:0]     sum;
  logic [2*C_WIDTH-1:0] prod_step;

  assign sum       = prod_q[0] ? ({1'b0, prod_q[2*C_WIDTH-1:C_WIDTH]} + {1'b0, a_mag_q})
                               :  {1'b0, prod_q[2*C_WIDTH-1:C_WIDTH]};
  assign prod_step = {sum, prod_q[C_WIDTH-1:1]};

  // FSM next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.InRdy_SO  = 1'b0;
    bus.OutVld_SO = 1'b0;
    case (state_q)
      IDLE: begin
        bus.InRdy_SO = 1'b1;
        if (bus.InVld_SI) state_d = MULT;
      end
      MULT: begin
        if (cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        bus.OutVld_SO = 1'b1;
        if (bus.OutRdy_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      prod_q    <= '0;
      a_mag_q   <= '0;
      cnt_q     <= '0;
      res_inv_q <= 1'b0;
      hi_sel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.InVld_SI) begin
          prod_q    <= {{C_WIDTH{1'b0}}, b_mag};
          a_mag_q   <= a_mag;
          cnt_q     <= C_LOG_WIDTH'(C_WIDTH - 1);
          res_inv_q <= a_neg ^ b_neg;
          hi_sel_q  <= (bus.OpCode_SI != 2'd0);
        end
        MULT: begin
          prod_q <= prod_step;
          if (cnt_q != '0) cnt_q <= cnt_q - C_LOG_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up at full width, then half select; registers only.
  logic [2*C_WIDTH-1:0] prod_signed;

  assign prod_signed = res_inv_q ? -prod_q : prod_q;
  assign bus.Res_DO  = hi_sel_q ? prod_signed[2*C_WIDTH-1:C_WIDTH] : prod_signed[C_WIDTH-1:0];

endmodule

// File: tb/tb_riscv_mult_serial.sv
module tb_riscv_mult_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  riscv_mult_serial_if #(.C_WIDTH(32)) bus ();

  riscv_mult_serial #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent wide-arithmetic reference.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0]  ax, bx;
    logic signed [131:0] p;
    ax = (op == 2'd1 || op == 2'd2) ? {{34{a[31]}}, a} : {34'b0, a};
    bx = (op == 2'd1) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = 132'(ax) * 132'(bx);
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op, return the result seen on the first OutVld cycle and the
  // latency counted with the cycle after the accepting edge as cycle 1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit pulse,
                        output logic [31:0] res, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.InRdy_SO && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_rdy_before_op", {63'b0, bus.InRdy_SO}, 64'd1);
    bus.OpA_DI = a; bus.OpB_DI = b; bus.OpCode_SI = op; bus.InVld_SI = 1'b1;
    @(posedge clk); #1;
    bus.InVld_SI = 1'b0;
    bus.OpA_DI = $urandom; bus.OpB_DI = $urandom;
    lat = 1;
    while (!bus.OutVld_SO && lat < 100) begin
      if (pulse) begin
        bus.InVld_SI  = lat[0];
        bus.OpA_DI    = $urandom;
        bus.OpCode_SI = 2'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.InVld_SI = 1'b0;
    res = bus.Res_DO;
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        bus.InVld_SI = 1'b1;
        bus.OpB_DI   = $urandom;
      end
      @(posedge clk); #1;
      chk("stall_out_vld", {63'b0, bus.OutVld_SO}, 64'd1);
      chk("stall_res", {32'b0, bus.Res_DO}, {32'b0, res});
    end
    bus.InVld_SI  = 1'b0;
    bus.OutRdy_SI = 1'b1;
    @(posedge clk); #1;
    bus.OutRdy_SI = 1'b0;
    chk("idle_after_ack", {62'b0, bus.InRdy_SO, bus.OutVld_SO}, 64'b10);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int          lat;
    bit          seen;

    bus.OpA_DI = '0; bus.OpB_DI = '0; bus.OpCode_SI = '0;
    bus.InVld_SI = 1'b0; bus.OutRdy_SI = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", {63'b0, bus.InRdy_SO}, 64'd1);
    chk("rst_out_vld", {63'b0, bus.OutVld_SO}, 64'd0);
    chk("rst_res", {32'b0, bus.Res_DO}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // MUL -1 x -1, plus latency
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat);
    chk("mul_ff_res", {32'b0, res}, 64'h00000001);
    chk("mul_ff_latency", 64'(lat), 64'd33);

    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat);
    chk("mulhu_ff_res", {32'b0, res}, 64'hFFFFFFFE);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat);
    chk("mulh_ff_res", {32'b0, res}, 64'h00000000);
    run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat);
    chk("mulhsu_ff_res", {32'b0, res}, 64'hFFFFFFFF);

    // Most negative operands and zero operand
    run_op(2'd1, 32'h80000000, 32'h80000000, 0, 1'b0, res, lat);
    chk("mulh_min_min", {32'b0, res}, 64'h40000000);
    run_op(2'd1, 32'hFFFFFFFB, 32'h00000000, 0, 1'b0, res, lat);
    chk("mulh_zero", {32'b0, res}, 64'h00000000);
    run_op(2'd2, 32'h00000000, 32'h80000001, 0, 1'b0, res, lat);
    chk("mulhsu_zero", {32'b0, res}, 64'h00000000);

    // MUL low half independent of signs: -3 * 5
    run_op(2'd0, 32'hFFFFFFFD, 32'h00000005, 0, 1'b0, res, lat);
    chk("mul_neg3x5", {32'b0, res}, 64'hFFFFFFF1);
    // MULH -3 * 5 = -15 -> high half all ones
    run_op(2'd1, 32'hFFFFFFFD, 32'h00000005, 0, 1'b0, res, lat);
    chk("mulh_neg3x5", {32'b0, res}, 64'hFFFFFFFF);

    // 10-cycle output stall with InVld pulses in MULT and FINISH
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 1'b1, res, lat);
    chk("stall_pulse_res", {32'b0, res}, 64'hFFFFFFFE);
    chk("stall_pulse_latency", 64'(lat), 64'd33);

    // Reset in the middle of MULT
    @(negedge clk);
    bus.OpA_DI = 32'h12345678; bus.OpB_DI = 32'h9; bus.OpCode_SI = 2'd0; bus.InVld_SI = 1'b1;
    @(posedge clk); #1;
    bus.InVld_SI = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_rdy", {63'b0, bus.InRdy_SO}, 64'd1);
    chk("abort_out_vld", {63'b0, bus.OutVld_SO}, 64'd0);
    chk("abort_res", {32'b0, bus.Res_DO}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after_release", {63'b0, bus.InRdy_SO}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= bus.OutVld_SO;
    end
    chk("abort_no_out_vld", {63'b0, seen}, 64'd0);
    run_op(2'd0, 32'd7, 32'd6, 0, 1'b0, res, lat);
    chk("after_abort_7x6", {32'b0, res}, 64'h0000002A);

    // Random ops, all opcodes, random stalls
    for (int n = 0; n < 24; n++) begin
      op = 2'(n % 4);
      a  = $urandom;
      b  = $urandom;
      if (n == 5) a = 32'h80000000;
      if (n == 6) b = 32'h80000000;
      run_op(op, a, b, int'($urandom_range(0, 3)), 1'b0, res, lat);
      chk($sformatf("rand_%0d_op%0d", n, op), {32'b0, res}, {32'b0, ref_res(op, a, b)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_mult_serial.md
RISCV_MULT_SERIAL -- requirements
Module: riscv_mult_serial

Interface
REQ-001 The block SHALL have parameter C_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter C_LOG_WIDTH, default 6, giving the counter width; it SHALL equal $clog2(C_WIDTH+1), checked by an elaboration assertion guarded by SKIP_ASSERT.
REQ-003 Clk_CI  input  1  clock; all registers update on the rising edge.
REQ-004 Rst_RBI  input  1  reset, asynchronous, active-low.
REQ-005 OpA_DI  input  C_WIDTH  multiplicand (operand A).
REQ-006 OpB_DI  input  C_WIDTH  multiplier (operand B).
REQ-007 OpCode_SI  input  2  operation: 0 MUL (low half), 1 MULH (signed x signed, high half), 2 MULHSU (signed A x unsigned B, high half), 3 MULHU (unsigned x unsigned, high half).
REQ-008 InVld_SI  input  1  operands and opcode are valid.
REQ-009 InRdy_SO  output  1  the block can accept an operation.
REQ-010 OutVld_SO  output  1  Res_DO holds a valid result.
REQ-011 OutRdy_SI  input  1  the consumer accepts the result.
REQ-012 Res_DO  output  C_WIDTH  result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MULT and FINISH.
REQ-014 In IDLE: InRdy_SO=1 and OutVld_SO=0; InVld_SI=1 at a clock edge SHALL capture the operands and flags and move the FSM to MULT.
REQ-015 On capture, operand A signedness SHALL be OpCode_SI in {1,2}, and operand B signedness SHALL be OpCode_SI==1.
REQ-016 On capture, each signed operand with MSB=1 SHALL be loaded as its two's-complement magnitude; all other operands SHALL be loaded unchanged (-2^(C_WIDTH-1) yields magnitude 2^(C_WIDTH-1)).
REQ-017 On capture: ResInv = (A signed & A MSB) XOR (B signed & B MSB); HiSel = (OpCode_SI != 0).
REQ-018 On capture, the 2*C_WIDTH product register SHALL be loaded with {0, |B|}, and the counter with C_WIDTH-1.
REQ-019 Each MULT cycle, when product-register bit 0 = 1, the block SHALL compute the (C_WIDTH+1)-bit sum hi + |A|; otherwise it SHALL carry hi forward unchanged.
REQ-020 Each MULT cycle, the block SHALL then shift {carry, sum, lo} right by 1 into the product register, with no bit lost.
REQ-021 Each MULT cycle, the counter SHALL decrement while nonzero.
REQ-022 The MULT step performed with counter==0 SHALL be the last; the FSM SHALL then go to FINISH, giving exactly C_WIDTH MULT cycles.
REQ-023 In FINISH: OutVld_SO=1 and InRdy_SO=0; Res_DO SHALL stay stable until OutRdy_SI=1 at a clock edge, which moves the FSM to IDLE.
REQ-024 Latency SHALL be C_WIDTH+1 cycles from the accepting edge to the first cycle with OutVld_SO=1 (33 cycles for C_WIDTH=32).
REQ-025 The next operation SHALL be accepted no earlier than the edge after the FINISH->IDLE edge.
REQ-026 InVld_SI SHALL be ignored, and operands not sampled, in MULT and FINISH.
REQ-027 Output path: P = ResInv ? -(product) : product, computed at the full 2*C_WIDTH width.
REQ-028 Res_DO SHALL be P[2*C_WIDTH-1:C_WIDTH] when HiSel=1, and P[C_WIDTH-1:0] otherwise.
REQ-029 Res_DO SHALL be combinational from registers only, with no input-to-output combinational path.
REQ-030 Res_DO SHALL be architecturally valid only while OutVld_SO=1.
REQ-031 A zero operand SHALL give a result of 0 for every opcode and sign combination, since negation of 0 is 0.
REQ-032 MUL SHALL produce the same low half regardless of operand signs.
REQ-033 The unused default FSM encoding SHALL return to IDLE.

Reset
REQ-034 Rst_RBI=0 SHALL asynchronously force state IDLE and clear the product register, counter, ResInv and HiSel to 0.
REQ-035 Outputs during and after reset SHALL be InRdy_SO=1, OutVld_SO=0 and Res_DO=0.
REQ-036 Reset asserted in MULT or FINISH SHALL abandon the operation, produce no OutVld_SO pulse, and leave the block ready on the first edge after release.

Verification
REQ-037 MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> Res_DO=0x00000001, OutVld_SO first high exactly 33 cycles after the accepting edge.
REQ-038 Both operands A=0xFFFFFFFF, B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-039 MULH A=B=0x80000000 -> 0x40000000; MULH A=0xFFFFFFFB, B=0 -> 0x00000000.
REQ-040 OutRdy_SI held low 10 cycles in FINISH -> Res_DO and OutVld_SO stable throughout; InVld_SI pulses in MULT/FINISH with other operands -> no effect on the result.
REQ-041 Rst_RBI pulsed low at MULT cycle 15 -> immediate IDLE, Res_DO=0, no OutVld_SO; the next MUL 7x6 -> 0x0000002A.
REQ-042 Random back-to-back operations, all opcodes, random OutRdy_SI stalls -> every result matches a 64-bit reference model.
